pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Hazard-tracking and operand-forwarding block for the 5-stage RV32 pipeline. It records destination registers of in-flight instructions, stalls IF/ID on load-use hazards, inserts bubbles into ID/EX, and supplies forwarded EX operands. It sits beside the ID/EX boundary, fed by ID decode, the EX branch/jump decision (`flush`) and the MEM/WB result paths.

## Interface
- `XLEN`, 32, datapath width
- `REG_AW`, 5, register address width (4 = RV32E)
- `CNT_W`, 32, performance counter width
- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `flush` in 1: EX redirect (jump, jalr or taken branch); kills IF and ID instructions
- `id_valid` in 1: ID holds a real instruction
- `id_rs1`, `id_rs2` in REG_AW: ID source registers
- `id_use_rs1`, `id_use_rs2` in 1: source actually read
- `id_rd` in REG_AW, `id_reg_write` in 1, `id_mem_read` in 1: ID destination info
- `ex_rs1_rf`, `ex_rs2_rf` in XLEN: ID/EX-registered regfile operands
- `mem_alu_result` in XLEN: EX/MEM ALU result
- `wb_data` in XLEN, `wb_rd` in REG_AW, `wb_regwrite` in 1: writeback port
- `stall` out 1: hold PC and IF/ID
- `bubble` out 1: ID/EX control registers load zeros
- `ex_rs1_op`, `ex_rs2_op` out XLEN: forwarded EX operands
- `fwd_sel1`, `fwd_sel2` out 2: selected source (debug)
- `stall_cnt`, `flush_cnt` out CNT_W: performance counters

## Operation
- Tracker: three entries, E0 (EX), E1 (MEM), E2 (WB); each {valid, rd, reg_write, is_load}. E0 also holds the EX instruction's rs1/rs2 and their use bits.
- Every cycle: E2<-E1, E1<-E0. E0 takes ID info when `id_valid & ~stall & ~flush`; otherwise it takes an invalid entry.
- An entry matches register r when valid, reg_write, rd==r and rd!=0.
- Load-use: `stall` = `id_valid & ~flush` & E0.is_load & (E0 matches id_rs1 with id_use_rs1, or id_rs2 with id_use_rs2). `bubble` = stall | flush.
- Forward priority per operand:
  - E1 match and not load -> `mem_alu_result` (sel 1)
  - else E2 match -> `wb_data` (sel 2)
  - else capture flag set -> captured value (sel 3)
  - else regfile (sel 0)
- An E1 match on a load cannot occur under correct stalling. If it does, the E1 match is ignored and priority falls through to E2.
- Capture: when ID advances into E0 and `wb_regwrite` with `wb_rd`==id_rs (non-zero), `wb_data` is latched into a per-operand capture register and the flag is set. This closes the regfile same-cycle write/read gap.
- Register x0 never forwards and never stalls.
- `flush` beats `stall`: on a simultaneous flush, `stall`=0, `bubble`=1, and E0 gets an invalid entry.
- `stall_cnt` counts cycles with `stall`=1. `flush_cnt` counts cycles with `flush`=1. Both saturate at all-ones.

## Timing
- `stall`, `bubble`, operands and selects are combinational from registered entries and current inputs. There are no registered outputs besides the counters.
- Load-use costs exactly 1 stall cycle. After the stall, the load sits in E2 and is forwarded via `wb_data`.
- Flush effect: the entries for the two killed instructions never become valid.
- Reset (synchronous): all entries invalid, capture flags 0, counters 0. The next cycle shows `stall`=0, `bubble`=0, sel=0, and operands equal to the `_rf` inputs.
- `rst` mid-stall: stall drops the cycle after reset is sampled.

## Configuration
- `PIPE_FWD_EN` defined: full forwarding as above.
- `PIPE_FWD_EN` undefined: no E1/E2 forwarding, and selects are limited to 0 or 3 (capture is kept).
  - `stall` asserts whenever E0 or E1 matches a used ID source, with the same flush precedence.
  - This gives up to 2 stall cycles per RAW hazard.

## Structure
- `pipe_pkg` holds:
  - `fwd_sel_t` with FWD_RF=0, FWD_MEM=1, FWD_WB=2, FWD_CAP=3
  - the tracker entry struct
  - the `REG_ZERO` constant
- Sub-module `pipe_fwd_mux`: one instance per operand; takes entries, capture state and data, and returns operand plus select.

## Test plan
- `addi x5,x0,7; add x6,x5,x5` back-to-back -> no stall, sel1=sel2=1, ex operands 7, x6=14.
- `lw x5,0(x1)` (mem=0x55) then `add x6,x5,x0` -> `stall`=1 for 1 cycle, `bubble`=1, then sel1=2, operand 0x55.
- Writeback of x7=0x99 in the same cycle ID reads x7 -> capture, sel=3, operand 0x99.
- Load-use plus `flush` in the same cycle -> `stall`=0, `bubble`=1, `stall_cnt` unchanged, `flush_cnt`+1.
- Write to x0 followed by a use of x0 -> sel=0, no stall, operand 0.
- Build without `PIPE_FWD_EN`, dependent add pair -> 2 stall cycles, sel=0, correct result.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding unit.
// Tracker entry layout, forward-select encoding and x0 constant.
package pipe_pkg;

  localparam int RA_W = 5;

  typedef logic [RA_W-1:0] reg_t;

  localparam reg_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2,
    FWD_CAP = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic valid;
    reg_t rd;
    logic reg_write;
    logic is_load;
  } trk_t;

  // An in-flight entry produces register r (x0 never counts)
  function automatic logic hits(trk_t e, reg_t r);
    return e.valid && e.reg_write && (e.rd == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// ID/EX/MEM/WB side-band bundle between the pipeline and hazard unit.
// master = pipeline datapath, slave = pipe_hazard_unit.
interface pipe_hazard_unit_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              flush;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic [XLEN-1:0]   ex_rs1_rf;
  logic [XLEN-1:0]   ex_rs2_rf;
  logic [XLEN-1:0]   mem_alu_result;
  logic [XLEN-1:0]   wb_data;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;
  logic              stall;
  logic              bubble;
  logic [XLEN-1:0]   ex_rs1_op;
  logic [XLEN-1:0]   ex_rs2_op;
  logic [1:0]        fwd_sel1;
  logic [1:0]        fwd_sel2;

  modport master (
    output flush, id_valid, id_rs1, id_rs2,
    output id_use_rs1, id_use_rs2,
    output id_rd, id_reg_write, id_mem_read,
    output ex_rs1_rf, ex_rs2_rf, mem_alu_result,
    output wb_data, wb_rd, wb_regwrite,
    input  stall, bubble, ex_rs1_op, ex_rs2_op,
    input  fwd_sel1, fwd_sel2
  );

  modport slave (
    input  flush, id_valid, id_rs1, id_rs2,
    input  id_use_rs1, id_use_rs2,
    input  id_rd, id_reg_write, id_mem_read,
    input  ex_rs1_rf, ex_rs2_rf, mem_alu_result,
    input  wb_data, wb_rd, wb_regwrite,
    output stall, bubble, ex_rs1_op, ex_rs2_op,
    output fwd_sel1, fwd_sel2
  );
endinterface

// File: rtl/pipe_fwd_mux.sv
// Per-operand EX forwarding select (MEM > WB > capture > regfile).
// MEM/WB paths exist only when PIPE_FWD_EN is defined.
module pipe_fwd_mux
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  reg_t            rs,
  input  logic            use_rs,
`ifdef PIPE_FWD_EN
  input  trk_t            e1,
  input  trk_t            e2,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] wb_data,
`endif
  input  logic            cap,
  input  logic [XLEN-1:0] cap_data,
  input  logic [XLEN-1:0] rf_data,
  output logic [XLEN-1:0] op,
  output fwd_sel_t        sel
);

  // Pick the youngest producer; unused operands stay on the regfile
  always_comb begin
    op  = rf_data;
    sel = FWD_RF;
    priority case (1'b1)
`ifdef PIPE_FWD_EN
      (use_rs && hits(e1, rs) && !e1.is_load): begin
        op  = mem_data;
        sel = FWD_MEM;
      end
      (use_rs && hits(e2, rs)): begin
        op  = wb_data;
        sel = FWD_WB;
      end
`endif
      (use_rs && cap): begin
        op  = cap_data;
        sel = FWD_CAP;
      end
      default: begin
        op  = rf_data;
        sel = FWD_RF;
      end
    endcase
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard tracker, load-use stall and EX operand forwarding.
// PIPE_FWD_EN: full MEM/WB forwarding; undefined: stall on all RAW.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_unit_if.slave hz,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  reg_t id_rs1, id_rs2, id_rd, wb_rd;
  trk_t id_ent;
  trk_t e0, e1;
`ifdef PIPE_FWD_EN
  trk_t e2;
`endif
  reg_t            e0_rs1, e0_rs2;
  logic            e0_use1, e0_use2;
  logic            cap1, cap2;
  logic [XLEN-1:0] cap1_d, cap2_d;
  logic            hit0, hit1, raw;
  logic            stall, advance;
  fwd_sel_t        sel1, sel2;

  assign id_rs1 = reg_t'(hz.id_rs1);
  assign id_rs2 = reg_t'(hz.id_rs2);
  assign id_rd  = reg_t'(hz.id_rd);
  assign wb_rd  = reg_t'(hz.wb_rd);

  assign id_ent = '{valid: 1'b1, rd: id_rd,
                    reg_write: hz.id_reg_write,
                    is_load: hz.id_mem_read};

  // Does an older entry write a source ID is about to read
  always_comb begin
    hit0 = (hz.id_use_rs1 && hits(e0, id_rs1))
        || (hz.id_use_rs2 && hits(e0, id_rs2));
    hit1 = (hz.id_use_rs1 && hits(e1, id_rs1))
        || (hz.id_use_rs2 && hits(e1, id_rs2));
`ifdef PIPE_FWD_EN
    raw = e0.is_load && hit0;
`else
    raw = hit0 || hit1;
`endif
  end

  assign stall     = hz.id_valid & ~hz.flush & raw;
  assign advance   = hz.id_valid & ~stall & ~hz.flush;
  assign hz.stall  = stall;
  assign hz.bubble = stall | hz.flush;

  // Shift the tracker; capture same-cycle WB writes of ID sources
  always_ff @(posedge clk) begin
    if (rst) begin
      e0      <= '0;
      e1      <= '0;
`ifdef PIPE_FWD_EN
      e2      <= '0;
`endif
      e0_rs1  <= REG_ZERO;
      e0_rs2  <= REG_ZERO;
      e0_use1 <= 1'b0;
      e0_use2 <= 1'b0;
      cap1    <= 1'b0;
      cap2    <= 1'b0;
      cap1_d  <= '0;
      cap2_d  <= '0;
    end else begin
      e1 <= e0;
`ifdef PIPE_FWD_EN
      e2 <= e1;
`endif
      if (advance) begin
        e0      <= id_ent;
        e0_rs1  <= id_rs1;
        e0_rs2  <= id_rs2;
        e0_use1 <= hz.id_use_rs1;
        e0_use2 <= hz.id_use_rs2;
        cap1    <= hz.wb_regwrite && (wb_rd == id_rs1)
                && (id_rs1 != REG_ZERO);
        cap2    <= hz.wb_regwrite && (wb_rd == id_rs2)
                && (id_rs2 != REG_ZERO);
        cap1_d  <= hz.wb_data;
        cap2_d  <= hz.wb_data;
      end else begin
        e0      <= '0;
        e0_rs1  <= REG_ZERO;
        e0_rs2  <= REG_ZERO;
        e0_use1 <= 1'b0;
        e0_use2 <= 1'b0;
        cap1    <= 1'b0;
        cap2    <= 1'b0;
      end
    end
  end

  // Saturating stall/flush event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (hz.flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  pipe_fwd_mux #(.XLEN(XLEN)) u_fwd1 (
    .rs       (e0_rs1),
    .use_rs   (e0_use1),
`ifdef PIPE_FWD_EN
    .e1       (e1),
    .e2       (e2),
    .mem_data (hz.mem_alu_result),
    .wb_data  (hz.wb_data),
`endif
    .cap      (cap1),
    .cap_data (cap1_d),
    .rf_data  (hz.ex_rs1_rf),
    .op       (hz.ex_rs1_op),
    .sel      (sel1)
  );

  pipe_fwd_mux #(.XLEN(XLEN)) u_fwd2 (
    .rs       (e0_rs2),
    .use_rs   (e0_use2),
`ifdef PIPE_FWD_EN
    .e1       (e1),
    .e2       (e2),
    .mem_data (hz.mem_alu_result),
    .wb_data  (hz.wb_data),
`endif
    .cap      (cap2),
    .cap_data (cap2_d),
    .rf_data  (hz.ex_rs2_rf),
    .op       (hz.ex_rs2_op),
    .sel      (sel2)
  );

  assign hz.fwd_sel1 = sel1;
  assign hz.fwd_sel2 = sel2;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Randomized bench for pipe_hazard_unit against an in-order
// instruction-history model; small CNT_W so counters saturate.
module tb_pipe_hazard_unit;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_unit_if #(.XLEN(XLEN), .REG_AW(REG_AW)) hz ();

  pipe_hazard_unit #(
    .XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hz        (hz),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit ld;
    int rs[2];
    bit u[2];
  } ins_t;

  // hist[0]=EX, hist[1]=MEM, hist[2]=WB
  ins_t        hist[3];
  bit          capf[2];
  int unsigned capv[2];
  int          n_stall, n_flush;
  int          total = 0;
  int          bad = 0;
  int          cyc;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit writes(ins_t i, int r);
    return i.v && i.rw && (i.rd == r) && (r != 0);
  endfunction

  function automatic bit id_dep(ins_t i);
    return (hz.id_use_rs1 && writes(i, int'(hz.id_rs1)))
        || (hz.id_use_rs2 && writes(i, int'(hz.id_rs2)));
  endfunction

  function automatic bit want_stall();
    bit haz;
`ifdef PIPE_FWD_EN
    haz = hist[0].ld && id_dep(hist[0]);
`else
    haz = id_dep(hist[0]) || id_dep(hist[1]);
`endif
    return hz.id_valid && !hz.flush && haz;
  endfunction

  task automatic want_op(input int k, input logic [31:0] rf,
                         output logic [31:0] op, output logic [1:0] sel);
    int r;
    bit u;
    r = hist[0].rs[k];
    u = hist[0].u[k];
    op = rf;
    sel = 2'd0;
`ifdef PIPE_FWD_EN
    if (u && writes(hist[1], r) && !hist[1].ld) begin
      op = hz.mem_alu_result;
      sel = 2'd1;
    end else if (u && writes(hist[2], r)) begin
      op = hz.wb_data;
      sel = 2'd2;
    end else
`endif
    if (u && capf[k]) begin
      op = capv[k];
      sel = 2'd3;
    end
  endtask

  task automatic model_clock(input bit st);
    ins_t nop;
    nop = '{default: 0};
    if (rst) begin
      hist[0] = nop;
      hist[1] = nop;
      hist[2] = nop;
      capf[0] = 0;
      capf[1] = 0;
      n_stall = 0;
      n_flush = 0;
      return;
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    if (hz.id_valid && !st && !hz.flush) begin
      hist[0].v = 1;
      hist[0].rd = int'(hz.id_rd);
      hist[0].rw = hz.id_reg_write;
      hist[0].ld = hz.id_mem_read;
      hist[0].rs[0] = int'(hz.id_rs1);
      hist[0].rs[1] = int'(hz.id_rs2);
      hist[0].u[0] = hz.id_use_rs1;
      hist[0].u[1] = hz.id_use_rs2;
      for (int k = 0; k < 2; k++) begin
        capf[k] = hz.wb_regwrite && (int'(hz.wb_rd) == hist[0].rs[k])
               && (hist[0].rs[k] != 0);
        capv[k] = hz.wb_data;
      end
    end else begin
      hist[0] = nop;
      capf[0] = 0;
      capf[1] = 0;
    end
    if (st && n_stall < CMAX) n_stall++;
    if (hz.flush && n_flush < CMAX) n_flush++;
  endtask

  task automatic drive_random(input int c);
    rst             = (c < 2) || ($urandom_range(299) == 0);
    hz.flush        = ($urandom_range(9) == 0);
    hz.id_valid     = ($urandom_range(9) != 0);
    hz.id_rs1       = REG_AW'($urandom_range(3));
    hz.id_rs2       = REG_AW'($urandom_range(3));
    hz.id_use_rs1   = ($urandom_range(4) != 0);
    hz.id_use_rs2   = ($urandom_range(2) != 0);
    hz.id_rd        = REG_AW'($urandom_range(3));
    hz.id_reg_write = ($urandom_range(4) != 0);
    hz.id_mem_read  = ($urandom_range(2) == 0);
    hz.ex_rs1_rf    = $urandom;
    hz.ex_rs2_rf    = $urandom;
    hz.mem_alu_result = $urandom;
    hz.wb_data      = $urandom;
    hz.wb_rd        = REG_AW'($urandom_range(3));
    hz.wb_regwrite  = ($urandom_range(1) == 0);
  endtask

  initial begin
    bit          st;
    logic [31:0] op;
    logic [1:0]  sel;
    for (cyc = 0; cyc < 3000; cyc++) begin
      drive_random(cyc);
      @(negedge clk);
      st = want_stall();
      chk("stall", 32'(hz.stall), 32'(st));
      chk("bubble", 32'(hz.bubble), 32'(st | hz.flush));
      want_op(0, hz.ex_rs1_rf, op, sel);
      chk("op1", hz.ex_rs1_op, op);
      chk("sel1", 32'(hz.fwd_sel1), 32'(sel));
      want_op(1, hz.ex_rs2_rf, op, sel);
      chk("op2", hz.ex_rs2_op, op);
      chk("sel2", 32'(hz.fwd_sel2), 32'(sel));
      if (cyc >= 2) begin
        chk("stall_cnt", 32'(stall_cnt), 32'(n_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(n_flush));
      end
      if (cyc == 2) begin
        chk("rst_stall", 32'(hz.stall), 32'd0);
        chk("rst_sel1", 32'(hz.fwd_sel1), 32'd0);
        chk("rst_op2", hz.ex_rs2_op, hz.ex_rs2_rf);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
      end
      @(posedge clk);
      model_clock(st);
      #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
